ask_frame_controller: RTL
=========================

# ask_frame_controller

Sequences one ASK transmit burst: preamble, sync word, PRBS payload, then a carrier-off guard interval. The controller owns bit timing for the burst. It pulls payload bits from the PRBS source one at a time and drives the bit and carrier-gate inputs of the ASK modulator. It sits between the host control registers and the PRBS generator/modulator pair.

## Interface
Parameters:
- PREAMBLE_BITS, 16, alternating-bit preamble length (even, ≥2)
- SYNC_WORD, 16'h2DD4, sync pattern, sent MSB-first
- SYNC_BITS, 16, sync length in bits (≤ width of SYNC_WORD)
- GUARD_BITS, 8, carrier-off bit periods after the frame
- LEN_W, 12, payload length width

Ports:
- clk  in  1  50 MHz system clock
- reset  in  1  asynchronous, active-high reset
- bit_rate_sel  in  2  00=1 kbps (period 50000), 01=10 kbps (5000), 10=100 kbps (500), 11=1 kbps (50000); sampled only at start
- start  in  1  frame request; accepted only in IDLE
- payload_len  in  LEN_W  payload bit count; sampled at start; 0 = no payload
- abort  in  1  terminate the current frame
- prbs_bit  in  1  current payload bit from the PRBS source
- prbs_adv  out  1  one-cycle pulse; prbs_bit is consumed on this edge and the source must advance
- tx_bit  out  1  registered bit to the modulator
- tx_en  out  1  registered carrier gate (1 = carrier keyed by tx_bit)
- bit_strobe  out  1  one-cycle pulse on the last clock of each bit period
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse when the frame (or aborted frame) completes

## Operation
- States: IDLE → PREAMBLE → SYNC → PAYLOAD → GUARD → IDLE.
  - PAYLOAD is skipped when the latched length is 0 (SYNC → GUARD).
- IDLE: all outputs 0. On start=1 and abort=0:
  - latch the rate period and payload_len;
  - clear the bit counter and cycle counter;
  - enter PREAMBLE.
- PREAMBLE: tx_en=1; tx_bit = 1,0,1,0… starting with 1.
- SYNC: tx_en=1; tx_bit = SYNC_WORD[SYNC_BITS-1] down to [0].
- PAYLOAD: tx_en=1; each payload bit is loaded into tx_bit from prbs_bit.
  - prbs_adv is high in exactly the cycle whose ending edge loads that bit.
  - Exactly payload_len prbs_adv pulses per frame; prbs_adv is never high outside these loads.
- GUARD: tx_en=0, tx_bit=0 for GUARD_BITS periods. Then go to IDLE, pulse done, drop busy.
- Bit timing:
  - The cycle counter counts 0..P-1 per bit, where P is the latched period.
  - bit_strobe fires at count P-1; the next bit or state loads on that edge.
  - The counter is held at 0 in IDLE.
- abort=1 in PREAMBLE/SYNC/PAYLOAD: on the next edge enter GUARD with the counters cleared, tx_en=0, and no further prbs_adv.
  - A full GUARD_BITS guard follows, then done.
  - abort in GUARD or IDLE is ignored.
- start while busy is ignored. start and abort together in IDLE: start is ignored.
- bit_rate_sel and payload_len changes while busy have no effect.
- reset (any time): state IDLE; all counters and outputs 0 immediately; no done pulse.

## Timing
- Edge E0 samples start. Let P be the latched period.
- Bit k occupies cycles [E0 + k·P, E0 + (k+1)·P).
  - tx_en and the first preamble bit are valid from E0.
- Frame length: L = PREAMBLE_BITS + SYNC_BITS + N + GUARD_BITS bits.
- At edge E0 + L·P: done=1 for one cycle, busy=0, back in IDLE. A start in that done cycle is accepted.
- Payload bit j (0-based) is sampled at edge E0 + (PREAMBLE_BITS + SYNC_BITS + j)·P. The PRBS source has P−1 cycles to present the next bit.
- Abort sampled at edge Ea: GUARD starts at Ea, and done follows at Ea + GUARD_BITS·P.
- Counter widths: 16 bits for the cycle counter; the bit counter is max(LEN_W, log2 of the longest segment).

## Structure
- Shared package ask_pkg:
  - state enum;
  - rate-period constants 50000/5000/500, shared with the PRBS generator;
  - default SYNC_WORD.
- Sub-module bit_rate_divider (period select, counter, strobe, clear input). It is reusable by the PRBS generator.

## Test plan
- Rate 10, N=32, default params:
  - tx_bit reads 1010×8, then 0x2DD4 MSB-first, then 32 bits equal to the sampled prbs_bit;
  - exactly 32 prbs_adv pulses, each one P=500 apart;
  - done at E0 + 72·500 = 36000 cycles.
- Rate 01, N=0: no prbs_adv; tx_en high for 32·5000 cycles, then low for 8·5000; done at E0 + 200000.
- Abort during payload bit 5:
  - tx_en=0 next cycle;
  - prbs_adv count is 5 or 6 depending on alignment and never increases afterwards;
  - done 8·P after the abort edge.
- start pulsed while busy, and start+abort in IDLE: both ignored; no extra busy or done.
- Reset asserted mid-payload: tx_en, tx_bit, busy, prbs_adv go to 0 without waiting for a clock edge; no done. A following start then runs a normal frame.
- bit_rate_sel changed 00→10 mid-frame: bit periods stay 50000 until done.

Source files
------------

// File: rtl/ask_pkg.sv
// rtl/ask_pkg.sv - shared ASK burst types, rate periods and default sync word
package ask_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SYNC,
        S_PAYLOAD,
        S_GUARD
    } ask_state_t;

    localparam int          CNT_W             = 16;
    localparam logic [15:0] PERIOD_1K         = 16'd50000;
    localparam logic [15:0] PERIOD_10K        = 16'd5000;
    localparam logic [15:0] PERIOD_100K       = 16'd500;
    localparam logic [15:0] DEFAULT_SYNC_WORD = 16'h2DD4;

    function automatic logic [CNT_W-1:0] rate_period(input logic [1:0] sel);
        case (sel)
            2'b01:   return PERIOD_10K;
            2'b10:   return PERIOD_100K;
            default: return PERIOD_1K;
        endcase
    endfunction

endpackage

// File: rtl/bit_rate_divider.sv
// rtl/bit_rate_divider.sv - latched-period cycle counter with end-of-bit strobe
module bit_rate_divider
    import ask_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [1:0] rate_sel,
    input  logic       clear,
    input  logic       enable,
    output logic       strobe
);

    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period <= PERIOD_1K;
            count  <= '0;
        end else begin
            if (load) begin
                period <= rate_period(rate_sel);
            end
            // Held at zero while disabled so the first bit starts from a clean count
            if (clear || !enable || strobe) begin
                count <= '0;
            end else begin
                count <= count + 16'd1;
            end
        end
    end

    assign strobe = enable && (count == period - 16'd1);

endmodule

// File: rtl/ask_frame_controller.sv
// rtl/ask_frame_controller.sv - preamble/sync/PRBS payload/guard burst sequencer for the ASK modulator
module ask_frame_controller
    import ask_pkg::*;
#(
    parameter int          PREAMBLE_BITS = 16,
    parameter logic [15:0] SYNC_WORD     = DEFAULT_SYNC_WORD,
    parameter int          SYNC_BITS     = 16,
    parameter int          GUARD_BITS    = 8,
    parameter int          LEN_W         = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       bit_rate_sel,
    input  logic             start,
    input  logic [LEN_W-1:0] payload_len,
    input  logic             abort,
    input  logic             prbs_bit,
    output logic             prbs_adv,
    output logic             tx_bit,
    output logic             tx_en,
    output logic             bit_strobe,
    output logic             busy,
    output logic             done
);

    localparam int SEG_A   = (PREAMBLE_BITS > SYNC_BITS) ? PREAMBLE_BITS : SYNC_BITS;
    localparam int SEG_MAX = (SEG_A > GUARD_BITS) ? SEG_A : GUARD_BITS;
    localparam int SEG_W   = $clog2(SEG_MAX + 1);
    localparam int BIT_W   = (LEN_W > SEG_W) ? LEN_W : SEG_W;

    localparam logic [BIT_W-1:0] PRE_LAST   = BIT_W'(PREAMBLE_BITS - 1);
    localparam logic [BIT_W-1:0] SYNC_LAST  = BIT_W'(SYNC_BITS - 1);
    localparam logic [BIT_W-1:0] GUARD_LAST = BIT_W'(GUARD_BITS - 1);
    // Sync bits left-justified so the next bit to send is always bit 15
    localparam logic [15:0]      SYNC_ALIGNED = SYNC_WORD << (16 - SYNC_BITS);

    ask_state_t       state, state_d;
    logic [BIT_W-1:0] bit_cnt, bit_cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [15:0]      sync_sr, sync_sr_d;
    logic             tx_bit_d, tx_en_d, done_d;
    logic             strobe, div_load, div_clear;
    logic [BIT_W-1:0] pay_last;

    assign pay_last = BIT_W'(len_q) - BIT_W'(1);

    bit_rate_divider u_divider (
        .clk      (clk),
        .reset    (reset),
        .load     (div_load),
        .rate_sel (bit_rate_sel),
        .clear    (div_clear),
        .enable   (busy),
        .strobe   (strobe)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            len_q   <= '0;
            sync_sr <= '0;
            tx_bit  <= 1'b0;
            tx_en   <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            bit_cnt <= bit_cnt_d;
            len_q   <= len_d;
            sync_sr <= sync_sr_d;
            tx_bit  <= tx_bit_d;
            tx_en   <= tx_en_d;
            done    <= done_d;
        end
    end

    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt;
        len_d     = len_q;
        sync_sr_d = sync_sr;
        tx_bit_d  = tx_bit;
        tx_en_d   = tx_en;
        done_d    = 1'b0;
        prbs_adv  = 1'b0;
        div_load  = 1'b0;
        div_clear = 1'b0;

        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d   = S_PREAMBLE;
                    bit_cnt_d = '0;
                    len_d     = payload_len;
                    tx_bit_d  = 1'b1;
                    tx_en_d   = 1'b1;
                    div_load  = 1'b1;
                    div_clear = 1'b1;
                end
            end
            S_PREAMBLE: begin
                if (strobe) begin
                    if (bit_cnt == PRE_LAST) begin
                        state_d   = S_SYNC;
                        bit_cnt_d = '0;
                        tx_bit_d  = SYNC_ALIGNED[15];
                        sync_sr_d = SYNC_ALIGNED << 1;
                    end else begin
                        bit_cnt_d = bit_cnt + 1'b1;
                        tx_bit_d  = ~tx_bit;
                    end
                end
            end
            S_SYNC: begin
                if (strobe) begin
                    if (bit_cnt == SYNC_LAST) begin
                        bit_cnt_d = '0;
                        if (len_q != '0) begin
                            state_d  = S_PAYLOAD;
                            tx_bit_d = prbs_bit;
                            prbs_adv = 1'b1;
                        end else begin
                            state_d  = S_GUARD;
                            tx_bit_d = 1'b0;
                            tx_en_d  = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt + 1'b1;
                        tx_bit_d  = sync_sr[15];
                        sync_sr_d = sync_sr << 1;
                    end
                end
            end
            S_PAYLOAD: begin
                if (strobe) begin
                    if (bit_cnt == pay_last) begin
                        state_d   = S_GUARD;
                        bit_cnt_d = '0;
                        tx_bit_d  = 1'b0;
                        tx_en_d   = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt + 1'b1;
                        tx_bit_d  = prbs_bit;
                        prbs_adv  = 1'b1;
                    end
                end
            end
            S_GUARD: begin
                if (strobe) begin
                    if (bit_cnt == GUARD_LAST) begin
                        state_d   = S_IDLE;
                        bit_cnt_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                bit_cnt_d = '0;
                tx_bit_d  = 1'b0;
                tx_en_d   = 1'b0;
            end
        endcase

        // Abort overrides any bit load in the same cycle, including the PRBS pull
        if (abort && (state == S_PREAMBLE || state == S_SYNC || state == S_PAYLOAD)) begin
            state_d   = S_GUARD;
            bit_cnt_d = '0;
            tx_bit_d  = 1'b0;
            tx_en_d   = 1'b0;
            prbs_adv  = 1'b0;
            div_clear = 1'b1;
        end
    end

    assign busy       = (state != S_IDLE);
    assign bit_strobe = strobe;

endmodule
